// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider.
// Each channel runs a small IDLE/RUN FSM with a free-running period counter. New
// period/high-time values are captured into shadow registers through a valid/ready
// handshake. A running channel copies them into its active registers only when its
// period wraps, so no output period is ever cut short or stretched.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | channel disabled: cnt=0, clock_out=0, tick=0
//   ST_RUN  | channel counting 0..P-1, clock_out high while cnt < H
module clock_divider_multi #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int DEF_PERIOD = 1,
    parameter int DEF_HIGH   = 1
) (
    input  logic                      i_src_clk,
    input  logic                      i_reset,
    input  logic [NUM_CH-1:0]         i_ch_en,
    input  logic                      i_sync,
    input  logic                      i_cfg_valid,
    output logic                      o_cfg_ready,
    input  logic [NUM_CH*WIDTH-1:0]   i_cfg_period,
    input  logic [NUM_CH*WIDTH-1:0]   i_cfg_high,
    output logic [NUM_CH-1:0]         o_clock_out,
    output logic [NUM_CH-1:0]         o_tick
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] L_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] L_DEF_P = WIDTH'(DEF_PERIOD);
    localparam logic [WIDTH-1:0] L_DEF_H = WIDTH'(DEF_HIGH);

    state_t             r_state    [NUM_CH];
    logic [WIDTH-1:0]   r_cnt      [NUM_CH];
    logic [WIDTH-1:0]   r_per      [NUM_CH];
    logic [WIDTH-1:0]   r_high     [NUM_CH];
    logic [WIDTH-1:0]   r_sh_per   [NUM_CH];
    logic [WIDTH-1:0]   r_sh_high  [NUM_CH];
    logic [NUM_CH-1:0]  r_pend;
    logic [NUM_CH-1:0]  r_clk;
    logic [NUM_CH-1:0]  r_tick;
    logic               r_ready;

    state_t             w_state_nx [NUM_CH];
    logic [WIDTH-1:0]   w_cnt_nx   [NUM_CH];
    logic [WIDTH-1:0]   w_cnt_inc  [NUM_CH];
    logic [WIDTH-1:0]   w_per_nx   [NUM_CH];
    logic [WIDTH-1:0]   w_high_nx  [NUM_CH];
    logic [NUM_CH-1:0]  w_wrap;
    logic [NUM_CH-1:0]  w_apply;
    logic [NUM_CH-1:0]  w_pend_nx;
    logic [NUM_CH-1:0]  w_clk_nx;
    logic [NUM_CH-1:0]  w_tick_nx;
    logic               w_accept;

    assign o_cfg_ready = r_ready;
    assign o_clock_out = r_clk;
    assign o_tick      = r_tick;

    // Next-state, counter, config-apply and output decode for every channel.
    always_comb begin
        w_accept = i_cfg_valid & r_ready;
        for (int c = 0; c < NUM_CH; c++) begin
            // Period is max(N,1)+1, so the last count is max(N,1); comparing in
            // WIDTH bits lets N = all-ones wrap naturally without a wider counter.
            w_wrap[c]     = (r_cnt[c] == ((r_per[c] == '0) ? L_ONE : r_per[c]));
            w_cnt_inc[c]  = w_wrap[c] ? '0 : (r_cnt[c] + L_ONE);
            w_apply[c]    = r_pend[c] & ((r_state[c] == ST_IDLE) | ~i_ch_en[c] |
                                         i_sync | w_wrap[c]);
            w_per_nx[c]   = w_apply[c] ? r_sh_per[c]  : r_per[c];
            w_high_nx[c]  = w_apply[c] ? r_sh_high[c] : r_high[c];
            // Accept only happens with nothing pending, so set and clear never collide.
            w_pend_nx[c]  = w_accept ? 1'b1 : (w_apply[c] ? 1'b0 : r_pend[c]);

            w_state_nx[c] = r_state[c];
            w_cnt_nx[c]   = '0;
            w_clk_nx[c]   = 1'b0;
            w_tick_nx[c]  = 1'b0;
            if (!i_ch_en[c]) begin
                w_state_nx[c] = ST_IDLE;
            end else if (r_state[c] == ST_IDLE || i_sync) begin
                w_state_nx[c] = ST_RUN;
                w_clk_nx[c]   = (w_high_nx[c] != '0);
                w_tick_nx[c]  = 1'b1;
            end else begin
                w_cnt_nx[c]   = w_cnt_inc[c];
                w_clk_nx[c]   = (w_cnt_inc[c] < w_high_nx[c]);
                w_tick_nx[c]  = (w_cnt_inc[c] == '0);
            end
        end
    end

    // Register all channel state, shadow config and the handshake ready flag.
    always_ff @(posedge i_src_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c]   <= ST_IDLE;
                r_cnt[c]     <= '0;
                r_per[c]     <= L_DEF_P;
                r_high[c]    <= L_DEF_H;
                r_sh_per[c]  <= L_DEF_P;
                r_sh_high[c] <= L_DEF_H;
            end
            r_pend  <= '0;
            r_clk   <= '0;
            r_tick  <= '0;
            r_ready <= 1'b1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= w_state_nx[c];
                r_cnt[c]   <= w_cnt_nx[c];
                r_per[c]   <= w_per_nx[c];
                r_high[c]  <= w_high_nx[c];
                if (w_accept) begin
                    r_sh_per[c]  <= i_cfg_period[c*WIDTH +: WIDTH];
                    r_sh_high[c] <= i_cfg_high[c*WIDTH +: WIDTH];
                end
            end
            r_pend  <= w_pend_nx;
            r_clk   <= w_clk_nx;
            r_tick  <= w_tick_nx;
            r_ready <= ~|w_pend_nx;
        end
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed testbench for clock_divider_multi (4 channels, 8-bit fields).
module tb_clock_divider_multi;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       ch_en;
    logic                    sync;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [NUM_CH*WIDTH-1:0] cfg_period;
    logic [NUM_CH*WIDTH-1:0] cfg_high;
    logic [NUM_CH-1:0]       clock_out;
    logic [NUM_CH-1:0]       tick;

    int n_checks = 0;
    int n_fail   = 0;

    clock_divider_multi #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEF_PERIOD(1), .DEF_HIGH(1)
    ) dut (
        .i_src_clk   (clk),
        .i_reset     (rst_n),
        .i_ch_en     (ch_en),
        .i_sync      (sync),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_period(cfg_period),
        .i_cfg_high  (cfg_high),
        .o_clock_out (clock_out),
        .o_tick      (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_CH*WIDTH-1:0] pack4(input logic [WIDTH-1:0] c0,
            input logic [WIDTH-1:0] c1, input logic [WIDTH-1:0] c2, input logic [WIDTH-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic wait_ready();
        int k;
        for (k = 0; k < 20; k++) begin
            if (cfg_ready) break;
            step();
        end
        check("ready_return", {31'd0, cfg_ready}, 32'd1);
    endtask

    // Offer a config, wait (bounded) for the accepting edge, then wait for it to apply.
    task automatic cfg_write(input logic [NUM_CH*WIDTH-1:0] per, input logic [NUM_CH*WIDTH-1:0] hi);
        logic prev;
        logic acc;
        acc = 1'b0;
        cfg_period = per;
        cfg_high   = hi;
        cfg_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            prev = cfg_ready;
            step();
            if (prev) begin
                acc = 1'b1;
                break;
            end
        end
        cfg_valid = 1'b0;
        check("cfg_accept", {31'd0, acc}, 32'd1);
        check("ready_low_after_accept", {31'd0, cfg_ready}, 32'd0);
        wait_ready();
    endtask

    initial begin
        rst_n      = 1'b0;
        ch_en      = '0;
        sync       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        #12;
        check("rst_clock_out", {28'd0, clock_out}, 32'd0);
        check("rst_tick", {28'd0, tick}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // N=3,H=2 on ch0: 1,1,0,0 repeating, tick every 4th
        cfg_write(pack4(3, 3, 3, 3), pack4(2, 2, 2, 2));
        ch_en = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t1_out", {28'd0, clock_out}, {31'd0, (k % 4) < 2});
            check("t1_tick", {28'd0, tick}, {31'd0, (k % 4) == 0});
        end

        // ch0 N=0,H=1 div2; ch1 N=0,H=0 flat low; ch2 N=4,H=9 flat high
        ch_en = 4'b0000;
        step();
        cfg_write(pack4(0, 0, 4, 0), pack4(1, 0, 9, 0));
        ch_en = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            logic [3:0] eo, et;
            step();
            eo = {1'b0, 1'b1, 1'b0, (k % 2) == 0};
            et = {1'b0, (k % 5) == 0, (k % 2) == 0, (k % 2) == 0};
            check("t2_out", {28'd0, clock_out}, {28'd0, eo});
            check("t2_tick", {28'd0, tick}, {28'd0, et});
        end

        // Running N=7,H=4; offer N=3,H=1 mid-period
        ch_en = 4'b0000;
        step();
        cfg_write(pack4(7, 7, 7, 7), pack4(4, 4, 4, 4));
        ch_en = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            logic eo1, et1;
            step();
            if (k < 8) begin
                eo1 = (k % 8) < 4;
                et1 = (k % 8) == 0;
            end else begin
                eo1 = ((k - 8) % 4) < 1;
                et1 = ((k - 8) % 4) == 0;
            end
            check("t3_out", {28'd0, clock_out}, {31'd0, eo1});
            check("t3_tick", {28'd0, tick}, {31'd0, et1});
            if (k >= 3) check("t3_ready", {31'd0, cfg_ready}, {31'd0, k >= 8});
            if (k == 2) begin
                cfg_period = pack4(3, 3, 3, 3);
                cfg_high   = pack4(1, 1, 1, 1);
                cfg_valid  = 1'b1;
            end
            if (k == 3) cfg_valid = 1'b0;
        end

        // Sync: ch0 N=2,H=1 and ch1 N=4,H=2 out of phase, then pulse sync
        ch_en = 4'b0000;
        step();
        cfg_write(pack4(2, 4, 0, 0), pack4(1, 2, 0, 0));
        ch_en = 4'b0001;
        step();
        step();
        ch_en = 4'b0011;
        step();
        step();
        step();
        sync = 1'b1;
        for (int j = 0; j < 10; j++) begin
            logic [3:0] eo, et;
            step();
            sync = 1'b0;
            eo = {2'b00, (j % 5) < 2, (j % 3) < 1};
            et = {2'b00, (j % 5) == 0, (j % 3) == 0};
            check("t4_out", {28'd0, clock_out}, {28'd0, eo});
            check("t4_tick", {28'd0, tick}, {28'd0, et});
        end

        // Drop ch_en[2] mid-high, re-raise three cycles later
        ch_en = 4'b0000;
        step();
        cfg_write(pack4(5, 5, 5, 5), pack4(4, 4, 4, 4));
        ch_en = 4'b0100;
        step();
        check("t5_start_out", {28'd0, clock_out}, 32'h4);
        check("t5_start_tick", {28'd0, tick}, 32'h4);
        step();
        check("t5_high_out", {28'd0, clock_out}, 32'h4);
        ch_en = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_off_out", {28'd0, clock_out}, 32'h0);
            check("t5_off_tick", {28'd0, tick}, 32'h0);
        end
        ch_en = 4'b0100;
        for (int j = 0; j < 7; j++) begin
            step();
            check("t5_re_out", {28'd0, clock_out}, {29'd0, j % 6 < 4, 2'b00});
            check("t5_re_tick", {28'd0, tick}, {29'd0, j % 6 == 0, 2'b00});
        end

        // Reset mid-period with config pending
        ch_en = 4'b0000;
        step();
        cfg_write(pack4(7, 7, 7, 7), pack4(4, 4, 4, 4));
        ch_en = 4'b0001;
        step();
        step();
        cfg_period = pack4(3, 3, 3, 3);
        cfg_high   = pack4(1, 1, 1, 1);
        cfg_valid  = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("t6_pending", {31'd0, cfg_ready}, 32'd0);
        check("t6_running", {28'd0, clock_out}, 32'h1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_out", {28'd0, clock_out}, 32'h0);
        check("t6_rst_tick", {28'd0, tick}, 32'h0);
        check("t6_rst_ready", {31'd0, cfg_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        ch_en = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t6_def_out", {28'd0, clock_out}, (k % 2 == 0) ? 32'h9 : 32'h0);
            check("t6_def_tick", {28'd0, tick}, (k % 2 == 0) ? 32'h9 : 32'h0);
            check("t6_def_ready", {31'd0, cfg_ready}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
